// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register in front of the ALU: registers decoded fields and ALUCon,
// and builds the a/b/store operands through EX/MEM and MEM/WB forwarding muxes.
module alu_operand_stage #(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_funct,
  input  logic          id_alusrc,
  input  logic          id_regwrite,
  input  logic [W-1:0]  id_rs_data,
  input  logic [W-1:0]  id_rt_data,
  input  logic [W-1:0]  id_imm,
  input  logic [RA-1:0] id_rs,
  input  logic [RA-1:0] id_rt,
  input  logic [RA-1:0] id_rd,
  input  logic          exmem_regwrite,
  input  logic [RA-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RA-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_result,
  output logic [3:0]    ALUCon,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic [W-1:0]  ex_store_data,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic [RA-1:0] ex_rd,
  output logic          ex_illegal
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alucon_e;

  alucon_e       dec_alucon;
  logic          dec_illegal;

  logic [RA-1:0] ex_rs, ex_rt;
  logic [W-1:0]  ex_rs_data, ex_rt_data, ex_imm;
  logic          ex_alusrc;

  logic          fa_exmem, fa_memwb, fb_exmem, fb_memwb;
  logic [W-1:0]  fwd_rs, fwd_rt;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    dec_alucon  = ALU_ADD;
    dec_illegal = 1'b0;
    if (id_valid) begin
      unique case (id_aluop)
        2'b00: dec_alucon = ALU_ADD;
        2'b01: dec_alucon = ALU_SUB;
        2'b11: dec_alucon = ALU_SLT;
        2'b10: begin
          unique case (id_funct)
            6'b100000: dec_alucon = ALU_ADD;
            6'b100010: dec_alucon = ALU_SUB;
            6'b100100: dec_alucon = ALU_AND;
            6'b100101: dec_alucon = ALU_OR;
            6'b101010: dec_alucon = ALU_SLT;
            6'b100111: dec_alucon = ALU_NOR;
            default:   dec_illegal = 1'b1;
          endcase
        end
        default: dec_alucon = ALU_ADD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // A bubble looks exactly like the reset state, so it can never write a register.
      ALUCon      <= ALU_ADD;
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_illegal  <= 1'b0;
      ex_rd       <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_alusrc   <= 1'b0;
    end else if (!stall) begin
      ALUCon      <= dec_alucon;
      ex_valid    <= id_valid;
      ex_regwrite <= id_regwrite & id_valid;
      ex_illegal  <= dec_illegal;
      ex_rd       <= id_rd;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_alusrc   <= id_alusrc;
    end
  end

  // Register 0 is hardwired, so a write to it is never a forwarding source.
  assign fa_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rs);
  assign fa_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rs);
  assign fb_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rt);
  assign fb_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rt);

  // EX/MEM holds the newer value, so it wins when both stages match.
  assign fwd_rs = fa_exmem ? exmem_result : (fa_memwb ? memwb_result : ex_rs_data);
  assign fwd_rt = fb_exmem ? exmem_result : (fb_memwb ? memwb_result : ex_rt_data);

  assign a             = fwd_rs;
  assign ex_store_data = fwd_rt;
  assign b             = ex_alusrc ? ex_imm : fwd_rt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: decode table plus hand-written
// reset, forwarding, immediate-select, stall and flush sequences.
module tb_alu_operand_stage;

  localparam int W  = 32;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst, stall, flush;
  logic          id_valid, id_alusrc, id_regwrite;
  logic [1:0]    id_aluop;
  logic [5:0]    id_funct;
  logic [W-1:0]  id_rs_data, id_rt_data, id_imm;
  logic [RA-1:0] id_rs, id_rt, id_rd;
  logic          exmem_regwrite, memwb_regwrite;
  logic [RA-1:0] exmem_rd, memwb_rd;
  logic [W-1:0]  exmem_result, memwb_result;
  logic [3:0]    ALUCon;
  logic [W-1:0]  a, b, ex_store_data;
  logic          ex_valid, ex_regwrite, ex_illegal;
  logic [RA-1:0] ex_rd;

  int n_tests = 0;
  int n_fail  = 0;

  alu_operand_stage #(.W(W), .RA(RA)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_funct(id_funct),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ALUCon(ALUCon), .a(a), .b(b), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] exp_alucon;
    logic       exp_illegal;
  } dec_vec_t;

  dec_vec_t vecs[11];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks are made at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                        input logic src, input logic rw,
                        input logic [RA-1:0] rs, input logic [RA-1:0] rt, input logic [RA-1:0] rd,
                        input logic [W-1:0] rsd, input logic [W-1:0] rtd, input logic [W-1:0] imm);
    id_valid = v; id_aluop = op; id_funct = fn; id_alusrc = src; id_regwrite = rw;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 6'b100010, 4'b0110, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0};
    vecs[3]  = '{1'b1, 2'b10, 6'b100101, 4'b0001, 1'b0};
    vecs[4]  = '{1'b1, 2'b10, 6'b101010, 4'b0111, 1'b0};
    vecs[5]  = '{1'b1, 2'b10, 6'b100111, 4'b1100, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 6'b111111, 4'b0010, 1'b1};
    vecs[7]  = '{1'b1, 2'b00, 6'b100010, 4'b0010, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 6'b100100, 4'b0110, 1'b0};
    vecs[9]  = '{1'b1, 2'b11, 6'b100101, 4'b0111, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 6'b111111, 4'b0010, 1'b0};

    // Reset with random ID inputs; forwards of register 0 must be ignored.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 2'($urandom), 6'($urandom), 1'b1, 1'b1, 5'($urandom), 5'($urandom),
           5'($urandom), $urandom, $urandom, $urandom);
    exmem_regwrite = 1'b1; exmem_rd = '0; exmem_result = 32'hDEAD_0001;
    memwb_regwrite = 1'b1; memwb_rd = '0; memwb_result = 32'hDEAD_0002;
    step();
    step();
    check("rst_alucon", 32'(ALUCon), 32'h2);
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_regwrite", 32'(ex_regwrite), 0);
    check("rst_illegal", 32'(ex_illegal), 0);
    check("rst_rd", 32'(ex_rd), 0);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_store", ex_store_data, 0);
    rst = 1'b0;
    clear_fwd();

    // Decode table.
    for (int i = 0; i < 11; i++) begin
      set_id(vecs[i].valid, vecs[i].aluop, vecs[i].funct, 1'b0, 1'b1,
             5'd1, 5'd2, 5'(i + 3), 32'h0, 32'h0, 32'h0);
      step();
      check($sformatf("dec%0d_alucon", i), 32'(ALUCon), 32'(vecs[i].exp_alucon));
      check($sformatf("dec%0d_illegal", i), 32'(ex_illegal), 32'(vecs[i].exp_illegal));
      check($sformatf("dec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].valid));
      check($sformatf("dec%0d_regwrite", i), 32'(ex_regwrite), 32'(vecs[i].valid));
    end

    // Forwarding priority on operand a.
    set_id(1'b1, 2'b00, 6'h0, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd4, 32'd11, 32'h0);
    step();
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'd8;
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'd9;
    #1 check("fwd_exmem_a", a, 32'd8);
    check("fwd_no_b", b, 32'd11);
    exmem_regwrite = 1'b0;
    #1 check("fwd_memwb_a", a, 32'd9);
    exmem_regwrite = 1'b1; exmem_rd = '0; memwb_rd = '0;
    #1 check("fwd_reg0_a", a, 32'd4);
    clear_fwd();

    // Immediate select with rt forwarded from MEM/WB.
    set_id(1'b1, 2'b00, 6'h0, 1'b1, 1'b1, 5'd1, 5'd7, 5'd8, 32'd0, 32'h55, 32'hFFFF_FFFE);
    step();
    memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_result = 32'd2;
    #1 check("imm_b", b, 32'hFFFF_FFFE);
    check("imm_store", ex_store_data, 32'd2);
    id_alusrc = 1'b0;
    step();
    check("noimm_b", b, 32'd2);
    clear_fwd();

    // Stall holds state; forwards still re-evaluate.
    set_id(1'b1, 2'b00, 6'h0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd4, 32'd4, 32'h0);
    step();
    check("cap_alucon", 32'(ALUCon), 32'h2);
    check("cap_a", a, 32'd4);
    check("cap_b", b, 32'd4);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_id(1'b1, 2'b01, 6'h0, 1'b1, 1'b0, 5'(c + 10), 5'(c + 20), 5'd6,
             32'(c + 90), 32'(c + 95), 32'hABCD);
      step();
      check($sformatf("stall%0d_alucon", c), 32'(ALUCon), 32'h2);
      check($sformatf("stall%0d_a", c), a, 32'd4);
      check($sformatf("stall%0d_b", c), b, 32'd4);
      check($sformatf("stall%0d_rd", c), 32'(ex_rd), 32'd3);
      check($sformatf("stall%0d_regwrite", c), 32'(ex_regwrite), 32'd1);
    end
    exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd77;
    #1 check("stall_fwd_a", a, 32'd77);
    clear_fwd();

    // Flush together with stall inserts a bubble.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(ex_valid), 0);
    check("flush_alucon", 32'(ALUCon), 32'h2);
    check("flush_regwrite", 32'(ex_regwrite), 0);
    check("flush_rd", 32'(ex_rd), 0);
    check("flush_a", a, 0);

    // Reset during a stall clears the held instruction.
    stall = 1'b0;
    set_id(1'b1, 2'b10, 6'b111111, 1'b0, 1'b1, 5'd4, 5'd5, 5'd9, 32'd33, 32'd44, 32'h0);
    step();
    check("pre_rst_illegal", 32'(ex_illegal), 1);
    stall = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    check("midstall_rst_illegal", 32'(ex_illegal), 0);
    check("midstall_rst_valid", 32'(ex_valid), 0);
    check("midstall_rst_a", a, 0);
    check("midstall_rst_rd", 32'(ex_rd), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU. It captures decoded instruction fields from ID and generates the registered 4-bit ALUCon.
- It drives the ALU a/b operands through EX/MEM and MEM/WB forwarding muxes.
- It supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- W, 32, datapath width of a, b, immediate and forwarded results.
- RA, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all ID/EX state
- flush  in  1  load a bubble
- id_valid  in  1  ID holds a real instruction
- id_aluop  in  2  main-decoder ALU op class
- id_funct  in  6  R-type funct field
- id_alusrc  in  1  1 = b takes the immediate
- id_regwrite  in  1  instruction writes a register
- id_rs_data, id_rt_data  in  W  register-file read data
- id_imm  in  W  sign-extended immediate
- id_rs, id_rt, id_rd  in  RA  source and destination register numbers
- exmem_regwrite  in  1, exmem_rd  in  RA, exmem_result  in  W  EX/MEM forward source
- memwb_regwrite  in  1, memwb_rd  in  RA, memwb_result  in  W  MEM/WB forward source
- ALUCon  out  4  ALU operation, registered
- a, b  out  W  ALU operands, combinational from ID/EX regs and forward inputs
- ex_store_data  out  W  forwarded rt value for stores
- ex_valid, ex_regwrite  out  1  registered
- ex_rd  out  RA  registered
- ex_illegal  out  1  registered: unsupported funct

Behaviour:
- Priority at each rising edge: rst > flush > stall > capture.
- Reset:
  - ALUCon = 4'b0010.
  - ex_valid, ex_regwrite and ex_illegal = 0.
  - ex_rd = 0; all stored data and register numbers = 0.
  - Consequently a = b = ex_store_data = 0, unless a forward matches, which cannot happen for reg 0.
- Flush: identical values to reset. A bubble never writes a register.
- Stall: every ID/EX register holds its value. a and b still re-evaluate each cycle as the forward inputs change.
- Capture (no rst/flush/stall):
  - Load all id_* fields.
  - ex_valid <= id_valid.
  - ex_regwrite <= id_regwrite & id_valid.
- ALUCon decode, performed at capture time and registered (1-cycle latency ID->EX):
  - aluop 00 -> 0010 (add)
  - aluop 01 -> 0110 (sub)
  - aluop 11 -> 0111 (slt)
  - aluop 10 -> by funct:
    - 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 101010 -> 0111
    - 100111 -> 1100
    - any other -> 0010, with ex_illegal <= id_valid.
  - If id_valid = 0, ALUCon <= 0010 and ex_illegal <= 0.
- Forwarding for operand rs (fa) and operand rt (fb), evaluated independently from the stored rs and rt:
  - EX/MEM selected if exmem_regwrite, exmem_rd != 0 and exmem_rd == stored reg.
  - Else MEM/WB selected if memwb_regwrite, memwb_rd != 0 and memwb_rd == stored reg.
  - Else the stored register-file data is used.
  - When both sources match, EX/MEM has priority (newest value).
  - Register 0 is never forwarded.
- Operand outputs:
  - a = forwarded rs.
  - ex_store_data = forwarded rt.
  - b = stored imm if stored alusrc = 1; otherwise forwarded rt.
- Width: all datapaths are W bits with no extension inside the block. The immediate arrives already sign-extended.
- A stall and a flush asserted together produce a flush.
- Reset asserted mid-stall clears state on that edge.

Test Plan:
- Reset: assert rst for 2 cycles with random ID inputs -> ALUCon = 0010, ex_valid = 0, ex_regwrite = 0, a = b = 0.
- Decode sweep: aluop = 10 with funct 100000/100010/100100/100101/101010/100111/111111, id_valid = 1 -> next cycle ALUCon = 0010/0110/0000/0001/0111/1100/0010, ex_illegal = 1 only for 111111. Also aluop 00/01/11 -> 0010/0110/0111.
- Forwarding: stored rs = 5 with rs_data = 4, exmem_rd = 5, exmem_result = 8, memwb_rd = 5, memwb_result = 9, both regwrite = 1 -> a = 8. Drop exmem_regwrite -> a = 9. Set both rd = 0 -> a = 4.
- Immediate select: alusrc = 1, imm = 32'hFFFFFFFE, rt forwarded to 2 -> b = FFFFFFFE, ex_store_data = 2. Then alusrc = 0 -> b = 2.
- Stall/flush: capture add (4, 4), then change ID inputs while stall = 1 for 3 cycles -> ALUCon, a and b hold (0010, 4, 4). Assert flush and stall together -> next cycle ex_valid = 0, ALUCon = 0010, ex_regwrite = 0.
- Invalid slot: id_valid = 0, id_regwrite = 1, aluop = 10, funct = 111111 -> ex_regwrite = 0, ex_illegal = 0, ALUCon = 0010.
